// File: rtl/fork_join_sched.sv
// Fork/join batch scheduler: hands job indices 0..job_cnt-1 to NW workers in
// round-robin order, then waits for every in-flight job to report done before pulsing join_pulse.
module fork_join_sched #(
  parameter  int NW = 4,
  parameter  int N  = 128,
  localparam int IW = $clog2(N),
  localparam int PW = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [IW:0]   job_cnt,
  output logic          busy,
  output logic [NW-1:0] disp_vld,
  output logic [IW-1:0] disp_id,
  input  logic [NW-1:0] disp_rdy,
  input  logic [NW-1:0] done,
  output logic          join_pulse,
  output logic          err,
  output logic [1:0]    dbg_state
);

  // Handshake: a job moves to worker w when disp_vld[w] & disp_rdy[w]; once raised,
  // disp_vld and disp_id hold unchanged until accepted, then disp_vld drops for one cycle.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    JOIN     = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic [IW-1:0] next_id_q, next_id_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [NW-1:0] infl_q, infl_d;
  logic [NW-1:0] vld_q, vld_d;
  logic [IW-1:0] id_q, id_d;
  logic          join_q, join_d;
  logic          err_q, err_d;

  logic [NW-1:0] hs_mask, elig, stray;
  logic          hs, pick_ok, last_job, all_clear;
  logic [PW-1:0] pick_w, hs_w, rr_next, idx;

  assign hs_mask   = vld_q & disp_rdy;
  assign hs        = |hs_mask;
  assign elig      = ~infl_q & ~vld_q;
  assign stray     = done & ~infl_q;
  assign last_job  = ({1'b0, next_id_q} == (cnt_q - 1'b1));
  assign all_clear = ~|(infl_q & ~done);
  assign rr_next   = (hs_w == PW'(NW - 1)) ? '0 : hs_w + 1'b1;

  // Scan downward so the eligible worker closest to rr_q is the one left in pick_w.
  always_comb begin : rr_search
    pick_ok = 1'b0;
    pick_w  = '0;
    idx     = '0;
    for (int k = NW - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_q) + k) % NW);
      if (elig[idx]) begin
        pick_ok = 1'b1;
        pick_w  = idx;
      end
    end
  end

  always_comb begin : hs_encode
    hs_w = '0;
    for (int k = 0; k < NW; k++) begin
      if (hs_mask[k]) hs_w = PW'(k);
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    cnt_d     = cnt_q;
    next_id_d = next_id_q;
    rr_d      = rr_q;
    vld_d     = vld_q;
    id_d      = id_q;
    join_d    = 1'b0;
    err_d     = err_q | (|stray);
    infl_d    = (infl_q & ~done) | hs_mask;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (job_cnt != '0) begin
            cnt_d     = job_cnt;
            next_id_d = '0;
            state_d   = DISPATCH;
            if (pick_ok) begin
              vld_d = NW'(1) << pick_w;
              id_d  = '0;
            end
          end else begin
            join_d = 1'b1;
          end
        end
      end
      DISPATCH: begin
        if (hs) begin
          vld_d = '0;
          rr_d  = rr_next;
          if (last_job) state_d = JOIN;
          else          next_id_d = next_id_q + 1'b1;
        end else if ((vld_q == '0) && pick_ok) begin
          vld_d = NW'(1) << pick_w;
          id_d  = next_id_q;
        end
      end
      JOIN: begin
        if (all_clear) begin
          state_d = IDLE;
          join_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      next_id_q <= '0;
      rr_q      <= '0;
      infl_q    <= '0;
      vld_q     <= '0;
      id_q      <= '0;
      join_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      next_id_q <= next_id_d;
      rr_q      <= rr_d;
      infl_q    <= infl_d;
      vld_q     <= vld_d;
      id_q      <= id_d;
      join_q    <= join_d;
      err_q     <= err_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign disp_vld   = vld_q;
  assign disp_id    = id_q;
  assign join_pulse = join_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fork_join_sched.sv
// Bench for fork_join_sched: a job-level reference model predicts every dispatch and join,
// and a negedge monitor compares the DUT against it through an expected-event queue.
module tb_fork_join_sched;
  localparam int NW = 4;
  localparam int N  = 128;
  localparam int IW = $clog2(N);
  localparam int W  = 32;
  typedef logic [IW:0] cnt_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  cnt_t          job_cnt;
  logic          busy, join_pulse, err;
  logic [NW-1:0] disp_vld;
  logic [NW-1:0] disp_rdy = '0;
  logic [NW-1:0] done = '0;
  logic [IW-1:0] disp_id;
  logic [1:0]    dbg_state;

  fork_join_sched #(.NW(NW), .N(N)) dut (
    .clk(clk), .rstn(rstn), .start(start), .job_cnt(job_cnt), .busy(busy),
    .disp_vld(disp_vld), .disp_id(disp_id), .disp_rdy(disp_rdy), .done(done),
    .join_pulse(join_pulse), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  logic [W-1:0]  exp_q[$];
  logic [NW-1:0] act_vld[$];
  int            act_id[$];
  int            join_seen = 0;
  logic [NW-1:0] prev_vld = '0;
  int            s1_w[7] = '{0, 1, 2, 3, 0, 1, 2};

  // worker behaviour knobs
  int            rdy_mode = 0;
  logic [NW-1:0] rdy_force = '1;
  int            lat_lo = 1, lat_hi = 1;
  int            stray_pct = 0;
  int            stray_at = -1;
  logic [NW-1:0] stray_mask = '0;
  int            due[NW] = '{default: -1};

  // reference model state
  int m_phase = 0;
  int m_total = 0, m_next = 0, m_offer = -1, m_rr = 0;
  bit m_infl[NW];
  bit m_err = 1'b0, m_join = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [W-1:0] ev(logic [1:0] kind, logic [NW-1:0] v, logic [IW-1:0] id);
    return {cyc[15:0], kind, 6'(v), 1'b0, id};
  endfunction

  task automatic pop_cmp(string nm, logic [W-1:0] got);
    logic [W-1:0] want;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: got event %h, required none", nm, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s: got event %h, required %h", nm, got, want);
      end
    end
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk) begin : model
    bit old_infl[NW];
    int hs, pick, w;
    bit all_free;
    cyc++;
    m_join = 1'b0;
    if (!rstn) begin
      m_phase = 0; m_total = 0; m_next = 0; m_offer = -1; m_rr = 0; m_err = 1'b0;
      for (int i = 0; i < NW; i++) begin
        m_infl[i] = 1'b0;
        due[i]    = -1;
      end
      exp_q.delete();
    end else begin
      old_infl = m_infl;
      hs = -1;
      pick = -1;
      for (int i = 0; i < NW; i++)
        if (done[i] && !old_infl[i]) m_err = 1'b1;
      if (m_phase == 1 && m_offer >= 0 && disp_rdy[m_offer]) hs = m_offer;
      for (int k = NW - 1; k >= 0; k--) begin
        w = (m_rr + k) % NW;
        if (!old_infl[w]) pick = w;
      end
      case (m_phase)
        0: if (start) begin
          m_err = 1'b0;
          if (job_cnt == 0) begin
            m_join = 1'b1;
            exp_q.push_back(ev(2'd2, '0, '0));
          end else begin
            m_total = int'(job_cnt);
            m_next  = 0;
            m_phase = 1;
            m_offer = pick;
            exp_q.push_back(ev(2'd1, NW'(1) << pick, '0));
          end
        end
        1: if (hs >= 0) begin
          m_offer = -1;
          m_rr    = (hs + 1) % NW;
          if (m_next == m_total - 1) m_phase = 2;
          else m_next++;
        end else if (m_offer < 0 && pick >= 0) begin
          m_offer = pick;
          exp_q.push_back(ev(2'd1, NW'(1) << pick, IW'(m_next)));
        end
        default: begin
          all_free = 1'b1;
          for (int i = 0; i < NW; i++)
            if (old_infl[i] && !done[i]) all_free = 1'b0;
          if (all_free) begin
            m_phase = 0;
            m_join  = 1'b1;
            exp_q.push_back(ev(2'd2, '0, '0));
          end
        end
      endcase
      for (int i = 0; i < NW; i++) m_infl[i] = old_infl[i] && !done[i];
      if (hs >= 0) begin
        m_infl[hs] = 1'b1;
        due[hs]    = cyc + int'($urandom_range(lat_hi, lat_lo)) - 1;
      end
    end
  end

  // ---------------- worker driver ----------------
  always @(posedge clk) begin : workers
    #2;
    for (int i = 0; i < NW; i++) done[i] = (due[i] == cyc);
    if (stray_at == cyc) done = done | stray_mask;
    if (stray_pct > 0 && int'($urandom_range(99, 0)) < stray_pct)
      done[$urandom_range(NW - 1, 0)] = 1'b1;
    case (rdy_mode)
      0:       disp_rdy = '1;
      1:       disp_rdy = NW'($urandom);
      default: disp_rdy = rdy_force;
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [NW-1:0] m_vld;
    m_vld = (m_offer >= 0) ? (NW'(1) << m_offer) : '0;
    if (!rstn) begin
      chk("reset_outputs", 64'({busy, disp_vld, disp_id, join_pulse, err}), 64'd0);
    end else begin
      chk("disp_vld", 64'(disp_vld), 64'(m_vld));
      if (m_offer >= 0) chk("disp_id", 64'(disp_id), 64'(m_next));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("join_pulse", 64'(join_pulse), 64'(m_join));
      chk("err", 64'(err), 64'(m_err));
      if (disp_vld != '0 && prev_vld == '0) begin
        act_vld.push_back(disp_vld);
        act_id.push_back(int'(disp_id));
        pop_cmp("dispatch_event", ev(2'd1, disp_vld, disp_id));
      end
      if (join_pulse) begin
        join_seen++;
        pop_cmp("join_event", ev(2'd2, '0, '0));
      end
    end
    prev_vld = rstn ? disp_vld : '0;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(int n);
    start   = 1'b1;
    job_cnt = cnt_t'(n);
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while ((busy || m_phase != 0) && k < budget) begin
      tick();
      k++;
    end
    vectors++;
    if (busy || m_phase != 0) begin
      miscompares++;
      $display("FAIL batch_timeout: still busy after %0d cycles, required idle", budget);
    end
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  task automatic clear_logs();
    act_vld.delete();
    act_id.delete();
    join_seen = 0;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : main
    int n, k;
    rstn = 1'b0; start = 1'b0; job_cnt = '0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // seven jobs, always ready, done three cycles after each handshake
    lat_lo = 3; lat_hi = 3; rdy_mode = 0;
    clear_logs();
    launch(7);
    wait_idle(300);
    chk("s1_count", 64'(act_vld.size()), 64'd7);
    for (int i = 0; i < 7 && i < act_vld.size(); i++) begin
      chk("s1_worker", 64'(act_vld[i]), 64'(NW'(1) << s1_w[i]));
      chk("s1_id", 64'(act_id[i]), 64'(i));
    end
    chk("s1_joins", 64'(join_seen), 64'd1);

    // empty batch
    clear_logs();
    launch(0);
    chk("s2_busy", 64'(busy), 64'd0);
    chk("s2_join", 64'(join_pulse), 64'd1);
    wait_idle(10);
    chk("s2_no_dispatch", 64'(act_vld.size()), 64'd0);

    // stray done on an idle worker
    stray_mask = 4'b0100;
    stray_at   = cyc;
    repeat (3) tick();
    chk("s3_err_set", 64'(err), 64'd1);
    tick();
    chk("s3_err_sticky", 64'(err), 64'd1);
    lat_lo = 1; lat_hi = 1;
    launch(1);
    chk("s3_err_cleared", 64'(err), 64'd0);
    wait_idle(50);

    // worker 0 holds off its first job for five cycles
    do_reset();
    tick();
    clear_logs();
    lat_lo = 2; lat_hi = 2;
    rdy_mode = 2; rdy_force = 4'b1110;
    launch(3);
    for (int i = 0; i < 5; i++) begin
      chk("s4_hold_vld", 64'(disp_vld), 64'b0001);
      chk("s4_hold_id", 64'(disp_id), 64'd0);
      if (i < 4) tick();
    end
    tick();
    rdy_mode = 0;
    chk("s4_vld_c6", 64'(disp_vld), 64'b0001);
    tick();
    chk("s4_drop", 64'(disp_vld), 64'd0);
    wait_idle(100);
    chk("s4_count", 64'(act_vld.size()), 64'd3);
    if (act_vld.size() >= 2) begin
      chk("s4_job1_worker", 64'(act_vld[1]), 64'b0010);
      chk("s4_job1_id", 64'(act_id[1]), 64'd1);
    end

    // full-size batch, immediate completion
    clear_logs();
    lat_lo = 1; lat_hi = 1; rdy_mode = 0;
    launch(N);
    wait_idle(1000);
    chk("s5_count", 64'(act_id.size()), 64'(N));
    for (int i = 0; i < N && i < act_id.size(); i++)
      chk("s5_id", 64'(act_id[i]), 64'(i));
    chk("s5_joins", 64'(join_seen), 64'd1);

    // reset in the middle of a batch
    clear_logs();
    lat_lo = 5; lat_hi = 8;
    launch(10);
    k = 0;
    while (m_next < 4 && k < 200) begin
      tick();
      k++;
    end
    chk("s6_reached_job4", 64'(m_next), 64'd4);
    rstn = 1'b0;
    repeat (3) tick();
    chk("s6_no_join", 64'(join_seen), 64'd0);
    clear_logs();
    lat_lo = 1; lat_hi = 3;
    rstn = 1'b1;
    launch(2);
    wait_idle(100);
    chk("s6_count", 64'(act_vld.size()), 64'd2);
    if (act_vld.size() == 2) begin
      chk("s6_w0", 64'(act_vld[0]), 64'b0001);
      chk("s6_w1", 64'(act_vld[1]), 64'b0010);
      chk("s6_id1", 64'(act_id[1]), 64'd1);
    end

    // randomized batches with back-pressure, stray dones and ignored starts
    rdy_mode = 1; lat_lo = 1; lat_hi = 6; stray_pct = 4;
    for (int b = 0; b < 14; b++) begin
      n = int'($urandom_range(24, 0));
      launch(n);
      if (n > 2) begin
        repeat ($urandom_range(3, 0)) tick();
        start   = 1'b1;
        job_cnt = cnt_t'($urandom_range(N, 1));
        tick();
        start   = 1'b0;
      end
      wait_idle(2000);
    end
    stray_pct = 0;
    repeat (10) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
